datapath_ctrl: RTL and testbench

Instruction sequencer sitting directly upstream of the microprocessor datapath. Accepts 8-bit assembly instructions (CLR, MOV, ADC, SBC) over a valid/ready handshake, buffers them in a small FIFO, and issues one registered control word per cycle (clr, ce, w, sel, s, cin) that drives the datapath's control inputs directly. Illegal instructions are replaced by a NOP and flagged.

---
 rtl/datapath_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_datapath_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/datapath_ctrl.sv
// -----------------------------------------------------------------------------
// datapath_ctrl
//
// Instruction sequencer for the microprocessor datapath. 8-bit assembly
// instructions (CLR, MOV, ADC, SBC) are accepted over a valid/ready handshake,
// buffered in a small FIFO and issued one per cycle as a registered control
// word that drives the datapath control inputs directly. Illegal instructions
// are issued as a NOP word and raise a sticky error flag.
//
// Handshake: a push happens at a rising clk edge where instr_valid_i and
// instr_ready_o are both 1. instr_ready_o depends only on registered FIFO
// occupancy (it is !full), so a pop on the same edge never frees a slot for
// a push on that edge.
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n_i        in   asynchronous active-low reset
//   instr_i        in   [7:0] {op[7:6], dest[5:4], src[3:1], c[0]}
//   instr_valid_i  in   instr_i valid this cycle
//   instr_ready_o  out  FIFO not full
//   halt_i         in   1 = no pops, control word forced to NOP
//   clr_o          out  datapath clr
//   ce_o           out  [3:0] datapath clock enables (bit3 = A, bits2:0 = R2..R0)
//   w_o            out  [2:0] Rj loads A when bit j = 1, else Mj
//   sel_o          out  [1:0] B-operand register select
//   s_o            out  [2:0] ALU function
//   cin_o          out  ALU carry in
//   err_o          out  sticky illegal-instruction flag
//   idle_o         out  FIFO empty and current control word is NOP
//   exec_cnt_o     out  [CNT_W-1:0] popped-instruction count, wraps
// -----------------------------------------------------------------------------
module datapath_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n_i,
    input  logic [7:0]       instr_i,
    input  logic             instr_valid_i,
    output logic             instr_ready_o,
    input  logic             halt_i,
    output logic             clr_o,
    output logic [3:0]       ce_o,
    output logic [2:0]       w_o,
    output logic [1:0]       sel_o,
    output logic [2:0]       s_o,
    output logic             cin_o,
    output logic             err_o,
    output logic             idle_o,
    output logic [CNT_W-1:0] exec_cnt_o
);

    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Instruction FIFO
    // ------------------------------------------------------------------
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == DEPTH_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = instr_valid_i && !w_full;
    assign w_pop   = !w_empty && !halt_i;

    assign instr_ready_o = !w_full;

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= instr_i;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Decoder for the FIFO head entry
    // ------------------------------------------------------------------
    logic [7:0] w_head;
    logic [1:0] w_op;
    logic [1:0] w_dest;
    logic [2:0] w_src;
    logic       w_c;
    logic [2:0] w_dest_onehot;
    logic       w_src_is_reg;

    assign w_head        = r_mem[r_rd_ptr];
    assign w_op          = w_head[7:6];
    assign w_dest        = w_head[5:4];
    assign w_src         = w_head[3:1];
    assign w_c           = w_head[0];
    assign w_dest_onehot = 3'b001 << w_dest;
    // Register sources R0..R2 are 100..110; 111 is A.
    assign w_src_is_reg  = w_src[2] && (w_src != 3'b111);

    logic       w_d_clr;
    logic [3:0] w_d_ce;
    logic [2:0] w_d_w;
    logic [1:0] w_d_sel;
    logic [2:0] w_d_s;
    logic       w_d_cin;
    logic       w_d_illegal;

    always_comb begin
        w_d_clr     = 1'b0;
        w_d_ce      = 4'b0000;
        w_d_w       = 3'b000;
        w_d_sel     = 2'b00;
        w_d_s       = 3'b000;
        w_d_cin     = 1'b0;
        w_d_illegal = 1'b0;
        case (w_op)
            2'b00: begin
                w_d_clr = 1'b1;
            end
            2'b01: begin
                if (w_dest == 2'b11) begin
                    // MOV A,Rk: pass B through the ALU into A.
                    if (w_src_is_reg) begin
                        w_d_ce  = 4'b1000;
                        w_d_sel = w_src[1:0];
                        w_d_s   = 3'b010;
                    end else begin
                        w_d_illegal = 1'b1;
                    end
                end else if (w_src == 3'b111) begin
                    // MOV Rj,A
                    w_d_ce = {1'b0, w_dest_onehot};
                    w_d_w  = w_dest_onehot;
                end else if (!w_src[2] && (w_src[1:0] == w_dest)) begin
                    // MOV Rj,Mj; dest is never 11 here so src 011 cannot match.
                    w_d_ce = {1'b0, w_dest_onehot};
                end else begin
                    w_d_illegal = 1'b1;
                end
            end
            default: begin
                // ADC (10) / SBC (11)
                if (w_src_is_reg) begin
                    w_d_ce  = 4'b1000;
                    w_d_sel = w_src[1:0];
                    w_d_s   = (w_op == 2'b11) ? 3'b001 : 3'b000;
                    w_d_cin = w_c;
                end else begin
                    w_d_illegal = 1'b1;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Issue FSM with registered control word
    // ------------------------------------------------------------------
    state_t r_state;
    logic   r_word_nop;

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_IDLE;
            clr_o      <= 1'b0;
            ce_o       <= 4'b0000;
            w_o        <= 3'b000;
            sel_o      <= 2'b00;
            s_o        <= 3'b000;
            cin_o      <= 1'b0;
            r_word_nop <= 1'b1;
            err_o      <= 1'b0;
            exec_cnt_o <= '0;
        end else begin
            r_state <= w_pop ? ST_ISSUE : ST_IDLE;
            if (w_pop) begin
                // An illegal instruction decodes to all-zero fields, i.e. NOP.
                clr_o      <= w_d_clr;
                ce_o       <= w_d_ce;
                w_o        <= w_d_w;
                sel_o      <= w_d_sel;
                s_o        <= w_d_s;
                cin_o      <= w_d_cin;
                r_word_nop <= w_d_illegal;
                exec_cnt_o <= exec_cnt_o + 1'b1;
                if (w_d_illegal) begin
                    err_o <= 1'b1;
                end
            end else begin
                clr_o      <= 1'b0;
                ce_o       <= 4'b0000;
                w_o        <= 3'b000;
                sel_o      <= 2'b00;
                s_o        <= 3'b000;
                cin_o      <= 1'b0;
                r_word_nop <= 1'b1;
            end
        end
    end

    assign idle_o = w_empty && r_word_nop;

endmodule

// File: tb/tb_datapath_ctrl.sv
module tb_datapath_ctrl;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n_i;
  logic [7:0] instr_i;
  logic       instr_valid_i;
  logic       instr_ready_o;
  logic       halt_i;
  logic       clr_o;
  logic [3:0] ce_o;
  logic [2:0] w_o;
  logic [1:0] sel_o;
  logic [2:0] s_o;
  logic       cin_o;
  logic       err_o;
  logic       idle_o;
  logic [7:0] exec_cnt_o;

  datapath_ctrl #(.FIFO_DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk           (clk),
    .rst_n_i       (rst_n_i),
    .instr_i       (instr_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .halt_i        (halt_i),
    .clr_o         (clr_o),
    .ce_o          (ce_o),
    .w_o           (w_o),
    .sel_o         (sel_o),
    .s_o           (s_o),
    .cin_o         (cin_o),
    .err_o         (err_o),
    .idle_o        (idle_o),
    .exec_cnt_o    (exec_cnt_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // {clr, ce[3:0], w[2:0], sel[1:0], s[2:0], cin}
  function automatic logic [13:0] pk(input logic clr, input logic [3:0] ce, input logic [2:0] w,
                                     input logic [1:0] sel, input logic [2:0] s, input logic cin);
    return {clr, ce, w, sel, s, cin};
  endfunction

  // ---------------- directed vectors: {illegal, word} ----------------
  logic [7:0]  v_instr [16];
  logic [14:0] v_exp   [16];

  initial begin
    v_instr[0]  = 8'h40; v_exp[0]  = {1'b0, pk(0, 4'b0001, 3'b000, 2'b00, 3'b000, 0)}; // MOV R0,M0
    v_instr[1]  = 8'h52; v_exp[1]  = {1'b0, pk(0, 4'b0010, 3'b000, 2'b00, 3'b000, 0)}; // MOV R1,M1
    v_instr[2]  = 8'h78; v_exp[2]  = {1'b0, pk(0, 4'b1000, 3'b000, 2'b00, 3'b010, 0)}; // MOV A,R0
    v_instr[3]  = 8'hCB; v_exp[3]  = {1'b0, pk(0, 4'b1000, 3'b000, 2'b01, 3'b001, 1)}; // SBC R1,c=1
    v_instr[4]  = 8'h6E; v_exp[4]  = {1'b0, pk(0, 4'b0100, 3'b100, 2'b00, 3'b000, 0)}; // MOV R2,A
    v_instr[5]  = 8'h00; v_exp[5]  = {1'b0, pk(1, 4'b0000, 3'b000, 2'b00, 3'b000, 0)}; // CLR
    v_instr[6]  = 8'h42; v_exp[6]  = {1'b1, 14'd0};                                     // MOV R0,M1
    v_instr[7]  = 8'h8E; v_exp[7]  = {1'b1, 14'd0};                                     // ADC A
    v_instr[8]  = 8'hA9; v_exp[8]  = {1'b0, pk(0, 4'b1000, 3'b000, 2'b00, 3'b000, 1)}; // ADC R0,c=1
    v_instr[9]  = 8'h96; v_exp[9]  = {1'b1, 14'd0};                                     // ADC src 011
    v_instr[10] = 8'h7E; v_exp[10] = {1'b1, 14'd0};                                     // MOV A,A
    v_instr[11] = 8'h64; v_exp[11] = {1'b0, pk(0, 4'b0100, 3'b000, 2'b00, 3'b000, 0)}; // MOV R2,M2
    v_instr[12] = 8'hDC; v_exp[12] = {1'b0, pk(0, 4'b1000, 3'b000, 2'b10, 3'b001, 0)}; // SBC R2,c=0
    v_instr[13] = 8'h5A; v_exp[13] = {1'b1, 14'd0};                                     // MOV R1,R1
    v_instr[14] = 8'h34; v_exp[14] = {1'b0, pk(1, 4'b0000, 3'b000, 2'b00, 3'b000, 0)}; // CLR, junk fields
    v_instr[15] = 8'hC9; v_exp[15] = {1'b0, pk(0, 4'b1000, 3'b000, 2'b00, 3'b001, 1)}; // SBC R0,c=1
  end

  // ---------------- scoreboard ----------------
  logic [14:0] exp_q[$];
  logic [14:0] cur_exp;
  int          m_cnt;
  logic [7:0]  e_cnt;
  logic        e_err;
  logic [13:0] e_word;

  always @(posedge clk) begin
    logic        do_pop;
    logic        do_push;
    logic [14:0] item;
    if (!rst_n_i) begin
      exp_q.delete();
      m_cnt  = 0;
      e_cnt  = 8'd0;
      e_err  = 1'b0;
      e_word = 14'd0;
    end else begin
      do_pop  = (m_cnt != 0) && !halt_i;
      do_push = instr_valid_i && (m_cnt < DEPTH);
      e_word  = 14'd0;
      if (do_pop) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow expected queue empty at pop, time %0t", $time);
        end else begin
          item   = exp_q.pop_front();
          e_word = item[13:0];
          if (item[14]) e_err = 1'b1;
        end
        e_cnt = e_cnt + 8'd1;
      end
      if (do_push) exp_q.push_back(cur_exp);
      m_cnt = m_cnt + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
    end
    #1;
    chk("ctrl_word", {clr_o, ce_o, w_o, sel_o, s_o, cin_o}, e_word);
    chk("exec_cnt", exec_cnt_o, e_cnt);
    chk("err", err_o, e_err);
    chk("ready", instr_ready_o, m_cnt < DEPTH);
    chk("idle", idle_o, (m_cnt == 0) && (e_word == 14'd0));
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic push_cycle(input int idx);
    instr_valid_i = 1'b1;
    instr_i       = v_instr[idx];
    cur_exp       = v_exp[idx];
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    instr_valid_i = 1'b0;
    instr_i       = 8'h00;
    cur_exp       = 15'd0;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n_i       = 1'b0;
    instr_valid_i = 1'b0;
    instr_i       = 8'h00;
    halt_i        = 1'b0;
    cur_exp       = 15'd0;
    repeat (2) @(negedge clk);
    rst_n_i = 1'b1;

    // program stream
    for (int i = 0; i <= 4; i++) push_cycle(i);
    idle_cycles(3);
    chk("prog_cnt", exec_cnt_o, 32'd5);
    chk("prog_err", err_o, 32'd0);

    // CLR
    push_cycle(5);
    idle_cycles(3);

    // illegal pair
    push_cycle(6);
    push_cycle(7);
    idle_cycles(3);
    chk("illegal_err", err_o, 32'd1);
    chk("illegal_cnt", exec_cnt_o, 32'd8);

    // halt with a fifth push blocked by a full FIFO
    halt_i = 1'b1;
    push_cycle(0);
    push_cycle(1);
    push_cycle(11);
    push_cycle(8);
    push_cycle(12);
    chk("halt_full_ready", instr_ready_o, 32'd0);
    idle_cycles(2);
    halt_i = 1'b0;
    idle_cycles(6);

    // back-to-back stream of every vector
    for (int i = 0; i < 16; i++) push_cycle(i);
    idle_cycles(4);

    // asynchronous reset with entries queued
    halt_i = 1'b1;
    push_cycle(2);
    push_cycle(3);
    push_cycle(4);
    idle_cycles(1);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("async_word", {clr_o, ce_o, w_o, sel_o, s_o, cin_o}, 32'd0);
    chk("async_idle", idle_o, 32'd1);
    chk("async_err", err_o, 32'd0);
    chk("async_cnt", exec_cnt_o, 32'd0);
    chk("async_ready", instr_ready_o, 32'd1);
    @(negedge clk);
    halt_i  = 1'b0;
    rst_n_i = 1'b1;
    idle_cycles(1);

    // counter wrap: 258 pops -> 2
    for (int i = 0; i < 258; i++) push_cycle(15);
    idle_cycles(3);
    chk("wrap_cnt", exec_cnt_o, 32'd2);
    chk("drain", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
